// File: rtl/ad7760_emu.sv
// AD7760 parallel-bus device emulator: fixed-rate 24-bit ramp, drdy_n handshake,
// two-word frame reads over DB[15:0], and CTRL1/CTRL2 writes with register read-back.
module ad7760_emu #(
  parameter int          DECIM = 32,
  parameter logic [23:0] STEP  = 24'd1,
  parameter logic [23:0] INIT  = 24'd0
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        rest_n,
  input  logic        cs_n,
  input  logic        r_n_w,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        db_oe,
  output logic        drdy_n,
  output logic        ovr
);
  localparam int CW = $clog2(DECIM);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   sample_q, sample_d;
  logic [31:0]   ol_q, ol_d;
  logic          pend_v_q, pend_v_d;
  logic [23:0]   pend_q, pend_d;
  logic          ptr_q, ptr_d;
  logic          ovr_q, ovr_d;
  logic          drdy_n_q, drdy_n_d;
  logic [15:0]   db_out_q, db_out_d;
  logic          db_oe_q, db_oe_d;
  logic          cs_q, cs_d, cs_qq, cs_qq_d, rnw_q, rnw_d;
  logic [15:0]   ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
  logic          wphase_q, wphase_d;
  logic [7:0]    waddr_q, waddr_d;
  logic          arm_q, arm_d;
  logic [7:0]    rbaddr_q, rbaddr_d;

  logic        pd, tick, fall, rise, can_load, load;
  logic [23:0] new_s, load_val;
  logic [15:0] rb_data;

  always_comb begin
    state_d  = state_q;   cnt_d    = cnt_q;    sample_d = sample_q;
    ol_d     = ol_q;      pend_v_d = pend_v_q; pend_d   = pend_q;
    ptr_d    = ptr_q;     ovr_d    = ovr_q;    drdy_n_d = drdy_n_q;
    ctrl1_d  = ctrl1_q;   ctrl2_d  = ctrl2_q;  wphase_d = wphase_q;
    waddr_d  = waddr_q;   arm_d    = arm_q;    rbaddr_d = rbaddr_q;
    cs_d     = cs_n;      cs_qq_d  = cs_q;     rnw_d    = r_n_w;
    load     = 1'b0;      load_val = pend_q;

    pd    = ctrl2_q[0];
    tick  = !pd && (cnt_q == CW'(DECIM - 1));
    new_s = sample_q + STEP;
    fall  = cs_qq && !cs_q;
    rise  = !cs_qq && cs_q;

    if (!pd) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) sample_d = new_s;

    // OL must stay stable for the whole frame; samples landing mid-frame wait in the slot
    can_load = (state_q == IDLE) && !ptr_q && !fall;
    if (tick) begin
      if (can_load) begin
        load = 1'b1; load_val = new_s; pend_v_d = 1'b0;
      end else begin
        pend_v_d = 1'b1; pend_d = new_s;
      end
    end else if (pend_v_q && can_load) begin
      load = 1'b1; pend_v_d = 1'b0;
    end

    if (load) begin
      ol_d     = {load_val, 1'b1, ovr_q | !drdy_n_q, 6'b0};
      ovr_d    = ovr_q | !drdy_n_q;
      drdy_n_d = 1'b0;
    end

    case (rbaddr_q)
      8'd1:    rb_data = ctrl1_q;
      8'd2:    rb_data = ctrl2_q;
      default: rb_data = 16'h0000;
    endcase

    case (state_q)
      IDLE: if (fall) begin
        state_d = rnw_q ? RD : WR;
        if (rnw_q && !ptr_q && !arm_q) drdy_n_d = 1'b1;
      end
      RD: if (rise) begin
        state_d = IDLE;
        if (arm_q) arm_d = 1'b0;
        else begin
          ptr_d = !ptr_q;
          if (ptr_q) ovr_d = 1'b0;
        end
      end
      WR: if (rise) begin
        state_d = IDLE;
        if (!wphase_q) begin
          if (db_in[15]) begin
            arm_d = 1'b1; rbaddr_d = db_in[7:0];
          end else begin
            wphase_d = 1'b1; waddr_d = db_in[7:0];
          end
        end else begin
          wphase_d = 1'b0;
          if (waddr_q == 8'd1) ctrl1_d = db_in;
          if (waddr_q == 8'd2) ctrl2_d = db_in;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pd) drdy_n_d = 1'b1;

    db_oe_d  = (state_q == RD);
    db_out_d = 16'h0000;
    if (state_q == RD) db_out_d = arm_q ? rb_data : (ptr_q ? ol_q[15:0] : ol_q[31:16]);

    // chip reset from the controller lands on the next edge; cs history is cleared so
    // a cs_n already low at release needs a fresh high-low cycle
    if (!rest_n) begin
      state_d  = IDLE;  cnt_d    = '0;    sample_d = INIT;   ol_d     = '0;
      pend_v_d = 1'b0;  pend_d   = '0;    ptr_d    = 1'b0;   ovr_d    = 1'b0;
      drdy_n_d = 1'b1;  db_out_d = '0;    db_oe_d  = 1'b0;   cs_d     = 1'b0;
      cs_qq_d  = 1'b0;  rnw_d    = 1'b0;  ctrl1_d  = '0;     ctrl2_d  = '0;
      wphase_d = 1'b0;  waddr_d  = '0;    arm_d    = 1'b0;   rbaddr_d = '0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;  cnt_q    <= '0;    sample_q <= INIT;   ol_q     <= '0;
      pend_v_q <= 1'b0;  pend_q   <= '0;    ptr_q    <= 1'b0;   ovr_q    <= 1'b0;
      drdy_n_q <= 1'b1;  db_out_q <= '0;    db_oe_q  <= 1'b0;   cs_q     <= 1'b0;
      cs_qq    <= 1'b0;  rnw_q    <= 1'b0;  ctrl1_q  <= '0;     ctrl2_q  <= '0;
      wphase_q <= 1'b0;  waddr_q  <= '0;    arm_q    <= 1'b0;   rbaddr_q <= '0;
    end else begin
      state_q  <= state_d;  cnt_q    <= cnt_d;    sample_q <= sample_d; ol_q     <= ol_d;
      pend_v_q <= pend_v_d; pend_q   <= pend_d;   ptr_q    <= ptr_d;    ovr_q    <= ovr_d;
      drdy_n_q <= drdy_n_d; db_out_q <= db_out_d; db_oe_q  <= db_oe_d;  cs_q     <= cs_d;
      cs_qq    <= cs_qq_d;  rnw_q    <= rnw_d;    ctrl1_q  <= ctrl1_d;  ctrl2_q  <= ctrl2_d;
      wphase_q <= wphase_d; waddr_q  <= waddr_d;  arm_q    <= arm_d;    rbaddr_q <= rbaddr_d;
    end
  end

  assign db_out = db_out_q;
  assign db_oe  = db_oe_q;
  assign drdy_n = drdy_n_q;
  assign ovr    = ovr_q;
endmodule

// File: tb/tb_ad7760_emu.sv
// Bench for ad7760_emu: a table of bus operations with hand-computed read data,
// plus hand-written reset-timing and mid-read chip-reset sequences.
module tb_ad7760_emu;
  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        rest_n = 1'b1, rest_n2 = 1'b1;
  logic        cs_n = 1'b1, r_n_w = 1'b1;
  logic [15:0] db_in = 16'h0;
  logic [15:0] db_out, db_out2;
  logic        db_oe, db_oe2, drdy_n, drdy_n2, ovr, ovr2;

  int n_chk = 0, n_fail = 0;

  ad7760_emu u_dut (
    .mclk(mclk), .rst(rst), .rest_n(rest_n), .cs_n(cs_n), .r_n_w(r_n_w),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .drdy_n(drdy_n), .ovr(ovr));

  ad7760_emu #(.DECIM(32), .STEP(24'd3), .INIT(24'hFFFFFE)) u_dut2 (
    .mclk(mclk), .rst(rst), .rest_n(rest_n2), .cs_n(cs_n), .r_n_w(r_n_w),
    .db_in(db_in), .db_out(db_out2), .db_oe(db_oe2), .drdy_n(drdy_n2), .ovr(ovr2));

  always #5 mclk = ~mclk;

  typedef enum {OP_WAITDRDY, OP_READ, OP_WRITE, OP_HOLD, OP_WAITOVR, OP_CHKOVR} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] arg;
    logic [15:0] exp1;
    logic [15:0] exp2;
    bit          chk2;
    bit          chkdrdy;
  } vec_t;
  vec_t vec[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling clock edge.
  task automatic bus_read(output logic [15:0] d1, output logic [15:0] d2,
                          output logic oe, output logic rdy);
    cs_n = 1'b0; r_n_w = 1'b1;
    repeat (3) @(negedge mclk);
    d1 = db_out; d2 = db_out2; oe = db_oe; rdy = drdy_n;
    @(negedge mclk);
    cs_n = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  task automatic bus_write(input logic [15:0] d);
    cs_n = 1'b0; r_n_w = 1'b0; db_in = d;
    repeat (3) @(negedge mclk);
    chk("wr_oe", db_oe, 1'b0);
    cs_n = 1'b1;
    repeat (3) @(negedge mclk);
  endtask

  task automatic wait_drdy(input int budget, output int n);
    n = 0;
    while (drdy_n && n < budget) begin
      @(negedge mclk);
      n++;
    end
  endtask

  initial begin
    logic [15:0] d1, d2, w;
    logic        oe, rdy;
    int          n, bad;

    // table: tests 1..4
    vec.push_back('{OP_READ, 16'h0, 16'h0000, 16'h0000, 1'b1, 1'b1});
    vec.push_back('{OP_READ, 16'h0, 16'h0180, 16'h0180, 1'b1, 1'b0});
    for (int s = 2; s <= 9; s++) begin
      w = {8'h00, 8'(s)};
      vec.push_back('{OP_WAITDRDY, 16'd40, 16'h0, 16'h0, 1'b0, 1'b0});
      vec.push_back('{OP_READ, 16'h0, 16'h0000, 16'h0000, s == 2, 1'b1});
      vec.push_back('{OP_READ, 16'h0, {w[7:0], 8'h80}, 16'h0480, s == 2, 1'b0});
    end
    vec.push_back('{OP_CHKOVR,   16'h0,  16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WAITDRDY, 16'd40, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_CHKOVR,   16'h0,  16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WAITOVR,  16'd40, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_READ,     16'h0,  16'h0000, 16'h0, 1'b0, 1'b1});
    vec.push_back('{OP_READ,     16'h0,  16'h0BC0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_CHKOVR,   16'h0,  16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WAITDRDY, 16'd40, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WRITE,    16'h0002, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WRITE,    16'h0001, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_HOLD,     16'd200,  16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WRITE,    16'h8002, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_READ,     16'h0,    16'h0001, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WRITE,    16'h0002, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WRITE,    16'h0000, 16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_WAITDRDY, 16'd60,   16'h0, 16'h0, 1'b0, 1'b0});
    vec.push_back('{OP_READ,     16'h0,    16'h0000, 16'h0, 1'b0, 1'b1});
    vec.push_back('{OP_READ,     16'h0,    16'h0D80, 16'h0, 1'b0, 1'b0});

    // test 1: reset state and first-sample timing
    repeat (3) @(negedge mclk);
    chk("rst_db_out", db_out, 16'h0);
    chk("rst_db_oe", db_oe, 1'b0);
    chk("rst_drdy_n", drdy_n, 1'b1);
    chk("rst_ovr", ovr, 1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge mclk);
      if (c == 31) chk("drdy_before_first", drdy_n, 1'b1);
      if (c == 32) chk("drdy_first", drdy_n, 1'b0);
    end

    for (int i = 0; i < vec.size(); i++) begin
      case (vec[i].op)
        OP_WAITDRDY: begin
          wait_drdy(int'(vec[i].arg), n);
          chk($sformatf("v%0d_drdy_wait", i), drdy_n, 1'b0);
        end
        OP_READ: begin
          bus_read(d1, d2, oe, rdy);
          chk($sformatf("v%0d_rd_oe", i), oe, 1'b1);
          chk($sformatf("v%0d_rd_data", i), d1, vec[i].exp1);
          if (vec[i].chk2) chk($sformatf("v%0d_rd_data2", i), d2, vec[i].exp2);
          if (vec[i].chkdrdy) chk($sformatf("v%0d_rd_drdy", i), rdy, 1'b1);
        end
        OP_WRITE: bus_write(vec[i].arg);
        OP_HOLD: begin
          bad = 0;
          for (int c = 0; c < int'(vec[i].arg); c++) begin
            @(negedge mclk);
            if (!drdy_n) bad++;
          end
          chk($sformatf("v%0d_pd_drdy_low_cycles", i), bad, 0);
        end
        OP_WAITOVR: begin
          n = 0;
          while (!ovr && n < int'(vec[i].arg)) begin
            @(negedge mclk);
            n++;
          end
          chk($sformatf("v%0d_ovr_set", i), ovr, 1'b1);
        end
        OP_CHKOVR: chk($sformatf("v%0d_ovr_clr", i), ovr, 1'b0);
        default: ;
      endcase
    end

    // test 6: chip reset in the middle of a word-1 read
    wait_drdy(40, n);
    chk("t6_drdy", drdy_n, 1'b0);
    bus_read(d1, d2, oe, rdy);
    chk("t6_w0", d1, 16'h0000);
    cs_n = 1'b0; r_n_w = 1'b1;
    repeat (3) @(negedge mclk);
    chk("t6_oe_before", db_oe, 1'b1);
    rest_n = 1'b0;
    @(negedge mclk);
    chk("t6_oe_after", db_oe, 1'b0);
    chk("t6_drdy_after", drdy_n, 1'b1);
    chk("t6_dbout_after", db_out, 16'h0);
    repeat (2) @(negedge mclk);
    cs_n = 1'b1; rest_n = 1'b1;
    wait_drdy(40, n);
    chk("t6_first_sample_delay", n, 32);
    bus_read(d1, d2, oe, rdy);
    chk("t6_rel_w0", d1, 16'h0000);
    bus_read(d1, d2, oe, rdy);
    chk("t6_rel_w1", d1, 16'h0180);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
